// File: rtl/gpio_multi_axis_writer_if.sv
// Bus bundle for gpio_multi_axis_writer: processor GPIO word in, NUM_CH AXI-Stream
// master channels and per-channel sticky overflow flags out.
interface gpio_multi_axis_writer_if #(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned WORD_W = 16
);
    logic [31:0]              gpio_in;
    logic [NUM_CH*WORD_W-1:0] m_tdata;
    logic [NUM_CH-1:0]        m_tvalid;
    logic [NUM_CH-1:0]        m_tready;
    logic [NUM_CH-1:0]        overflow;

    modport master (
        input  gpio_in,
        input  m_tready,
        output m_tdata,
        output m_tvalid,
        output overflow
    );

    modport slave (
        output gpio_in,
        output m_tready,
        input  m_tdata,
        input  m_tvalid,
        input  overflow
    );
endinterface

// File: rtl/gpio_multi_axis_writer.sv
// Assembles CHUNK_W-bit GPIO writes into WORD_W-bit words on NUM_CH independent
// AXI-Stream channels, each backed by a first-word fall-through FIFO.
module gpio_multi_axis_writer #(
    parameter int unsigned NUM_CH     = 2,
    parameter int unsigned BASE_ADDR  = 0,
    parameter int unsigned CHUNK_W    = 8,
    parameter int unsigned BEATS      = 2,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input logic                     clk,
    input logic                     rst,
    gpio_multi_axis_writer_if.master bus
);
    localparam int unsigned WORD_W    = CHUNK_W * BEATS;
    localparam int unsigned AW        = $clog2(FIFO_DEPTH);
    localparam int unsigned PW        = AW + 1;
    localparam int unsigned BEAT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned CTRL_ADDR = BASE_ADDR + NUM_CH;

    logic [31:0] g1, g2;
    logic        w_prev;

    logic [WORD_W-1:0] asm_q   [NUM_CH];
    logic [BEAT_W-1:0] beat_q  [NUM_CH];
    logic [WORD_W-1:0] mem     [NUM_CH][FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr  [NUM_CH];
    logic [PW-1:0]     rd_ptr  [NUM_CH];
    logic [NUM_CH-1:0] ovf_q;

    logic               strobe;
    logic [7:0]         addr;
    logic [CHUNK_W-1:0] chunk;
    logic               ctrl_hit;
    logic               unused_g2;

    logic [NUM_CH-1:0] hit, push, pop, full, empty;
    logic [WORD_W-1:0] asm_next [NUM_CH];

    // One action per rising edge of the synchronised w_clk strobe
    assign strobe    = g2[31] & ~w_prev;
    assign addr      = g2[23:16];
    assign chunk     = g2[CHUNK_W-1:0];
    assign ctrl_hit  = strobe && (addr == 8'(CTRL_ADDR));
    assign unused_g2 = ^g2;

    // Per-channel decode, FIFO status and output presentation
    always_comb begin
        hit          = '0;
        push         = '0;
        pop          = '0;
        full         = '0;
        empty        = '0;
        bus.m_tvalid = '0;
        bus.m_tdata  = '0;
        bus.overflow = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            asm_next[c] = WORD_W'({asm_q[c], chunk});
            hit[c]      = strobe && (addr == 8'(BASE_ADDR + c));
            push[c]     = hit[c] && (beat_q[c] == BEAT_W'(BEATS - 1));
            empty[c]    = (wr_ptr[c] == rd_ptr[c]);
            full[c]     = (wr_ptr[c][AW] != rd_ptr[c][AW]) &&
                          (wr_ptr[c][AW-1:0] == rd_ptr[c][AW-1:0]);
            pop[c]      = !empty[c] && bus.m_tready[c];
            bus.m_tvalid[c]                   = !empty[c];
            bus.m_tdata[c*WORD_W +: WORD_W]   = mem[c][rd_ptr[c][AW-1:0]];
            bus.overflow[c]                   = ovf_q[c];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            g1     <= '0;
            g2     <= '0;
            w_prev <= 1'b0;
            ovf_q  <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                asm_q[c]  <= '0;
                beat_q[c] <= '0;
                wr_ptr[c] <= '0;
                rd_ptr[c] <= '0;
                for (int d = 0; d < FIFO_DEPTH; d++) mem[c][d] <= '0;
            end
        end else begin
            g1     <= bus.gpio_in;
            g2     <= g1;
            w_prev <= g2[31];
            for (int c = 0; c < NUM_CH; c++) begin
                // Assembly: control clear wins; a completing beat wraps to 0 even if dropped
                if (ctrl_hit && g2[0]) begin
                    asm_q[c]  <= '0;
                    beat_q[c] <= '0;
                end else if (hit[c]) begin
                    asm_q[c]  <= asm_next[c];
                    beat_q[c] <= push[c] ? '0 : beat_q[c] + BEAT_W'(1);
                end

                if (ctrl_hit && g2[1])
                    ovf_q[c] <= 1'b0;
                else if (push[c] && full[c] && !pop[c])
                    ovf_q[c] <= 1'b1;

                // A full FIFO still accepts a push when the head leaves the same cycle
                if (push[c] && (!full[c] || pop[c])) begin
                    mem[c][wr_ptr[c][AW-1:0]] <= asm_next[c];
                    wr_ptr[c]                 <= wr_ptr[c] + PW'(1);
                end
                if (pop[c])
                    rd_ptr[c] <= rd_ptr[c] + PW'(1);
            end
        end
    end
endmodule

// File: tb/tb_gpio_multi_axis_writer.sv
// Scoreboard bench for gpio_multi_axis_writer (2 channels, 8-bit chunks, 2 beats, depth 4).
module tb_gpio_multi_axis_writer;
    typedef struct packed {
        logic [3:0]  ch;
        logic [15:0] data;
    } exp_t;

    logic clk;
    logic rst;
    gpio_multi_axis_writer_if #(.NUM_CH(2), .WORD_W(16)) bus ();

    gpio_multi_axis_writer #(
        .NUM_CH(2), .BASE_ADDR(0), .CHUNK_W(8), .BEATS(2), .FIFO_DEPTH(4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   tests = 0;
    int   fails = 0;
    exp_t exp_q[$];
    exp_t e;
    logic [3:0] tv;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: every handshake must match the head of the scoreboard
    always @(negedge clk) begin
        if (rst) begin
            for (int c = 0; c < 2; c++) begin
                if (bus.m_tvalid[c] && bus.m_tready[c]) begin
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_out: ch %0d data 0x%0h with nothing expected",
                                 c, bus.m_tdata[c*16 +: 16]);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_ch", 32'(c), 32'(e.ch));
                        chk("out_data", 32'(bus.m_tdata[c*16 +: 16]), 32'(e.data));
                    end
                end
            end
        end
    end

    // One GPIO write; samples m_tvalid[0] on the first 4 negedges after the w_clk rise
    task automatic gpio_write(input logic [7:0] a, input logic [15:0] d, input int hold,
                              output logic [3:0] tv0);
        tv0 = '0;
        @(negedge clk);
        bus.gpio_in = {1'b0, 7'd0, a, d};
        @(negedge clk);
        bus.gpio_in[31] = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (i < 4) tv0[i] = bus.m_tvalid[0];
        end
        bus.gpio_in[31] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (hold + i < 4) tv0[hold + i] = bus.m_tvalid[0];
        end
    endtask

    task automatic push_exp(input logic [3:0] ch, input logic [15:0] data);
        exp_t x;
        x.ch   = ch;
        x.data = data;
        exp_q.push_back(x);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        rst          = 1'b0;
        bus.gpio_in  = '0;
        bus.m_tready = '0;
        repeat (3) @(negedge clk);
        chk("rst_tvalid", 32'(bus.m_tvalid), 32'd0);
        chk("rst_tdata", bus.m_tdata, 32'd0);
        chk("rst_overflow", 32'(bus.overflow), 32'd0);
        rst = 1'b1;
        bus.m_tready = 2'b11;

        // Basic two-chunk word; first chunk lands in the upper byte
        push_exp(4'd0, 16'hABCD);
        gpio_write(8'd0, 16'h00AB, 3, tv);
        chk("first_chunk_no_valid", 32'(tv), 32'd0);
        gpio_write(8'd0, 16'h00CD, 3, tv);
        chk("latency_one_cycle_valid", 32'(tv), 32'b0100);
        drain("drain_basic");

        // Interleaved channels complete in order of their last chunk
        push_exp(4'd1, 16'h3456);
        push_exp(4'd0, 16'h1278);
        gpio_write(8'd0, 16'h0012, 3, tv);
        gpio_write(8'd1, 16'h0034, 3, tv);
        gpio_write(8'd1, 16'h0056, 3, tv);
        gpio_write(8'd0, 16'h0078, 3, tv);
        drain("drain_interleave");

        // Overflow: fifth word dropped on a full FIFO
        bus.m_tready = 2'b10;
        for (int w = 1; w <= 5; w++) begin
            if (w <= 4) push_exp(4'd0, 16'(w));
            gpio_write(8'd0, 16'h0000, 3, tv);
            gpio_write(8'd0, 16'(w), 3, tv);
            if (w == 4) chk("no_overflow_at_full", 32'(bus.overflow[0]), 32'd0);
        end
        chk("overflow_set", 32'(bus.overflow[0]), 32'd1);
        chk("overflow_ch1_clear", 32'(bus.overflow[1]), 32'd0);
        chk("stall_tvalid", 32'(bus.m_tvalid[0]), 32'd1);
        chk("stall_tdata_head", 32'(bus.m_tdata[15:0]), 32'h0001);
        bus.m_tready = 2'b11;
        drain("drain_overflow");
        chk("overflow_sticky", 32'(bus.overflow[0]), 32'd1);

        // Control write discards the partial word and clears overflow
        gpio_write(8'd0, 16'h00AA, 3, tv);
        gpio_write(8'd2, 16'h0003, 3, tv);
        chk("overflow_cleared", 32'(bus.overflow[0]), 32'd0);
        push_exp(4'd0, 16'h1122);
        gpio_write(8'd0, 16'h0011, 3, tv);
        gpio_write(8'd0, 16'h0022, 3, tv);
        drain("drain_ctrl");

        // Held w_clk acts once; out-of-range address is ignored
        gpio_write(8'd1, 16'h0077, 20, tv);
        chk("held_no_word", 32'(bus.m_tvalid), 32'd0);
        gpio_write(8'h7F, 16'h0099, 3, tv);
        chk("bad_addr_no_word", 32'(bus.m_tvalid), 32'd0);
        push_exp(4'd1, 16'h7788);
        gpio_write(8'd1, 16'h0088, 3, tv);
        drain("drain_held");

        // Reset with two queued words and one pending chunk
        bus.m_tready = 2'b10;
        gpio_write(8'd0, 16'h000A, 3, tv);
        gpio_write(8'd0, 16'h000B, 3, tv);
        gpio_write(8'd0, 16'h000C, 3, tv);
        gpio_write(8'd0, 16'h000D, 3, tv);
        gpio_write(8'd0, 16'h00EE, 3, tv);
        chk("pre_rst_tvalid", 32'(bus.m_tvalid[0]), 32'd1);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_tvalid", 32'(bus.m_tvalid), 32'd0);
        chk("async_rst_tdata", bus.m_tdata, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        bus.m_tready = 2'b11;
        push_exp(4'd0, 16'h3132);
        gpio_write(8'd0, 16'h0031, 3, tv);
        gpio_write(8'd0, 16'h0032, 3, tv);
        drain("drain_after_rst");
        repeat (5) @(negedge clk);
        chk("idle_end", 32'(bus.m_tvalid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
